// File: rtl/memory_responder_if.sv
// CPU-side byte memory bus: split read/write addresses, write strobe, registered read data and ready.
interface memory_responder_if #(
    parameter int addr_width = 9
);
    logic [addr_width-1:0] mem_raddr;
    logic [addr_width-1:0] mem_waddr;
    logic [7:0]            mem_data_in;
    logic                  mem_write;
    logic [7:0]            mem_data_out;
    logic                  mem_ready;

    modport master (
        output mem_raddr, mem_waddr, mem_data_in, mem_write,
        input  mem_data_out, mem_ready
    );

    modport slave (
        input  mem_raddr, mem_waddr, mem_data_in, mem_write,
        output mem_data_out, mem_ready
    );
endinterface

// File: rtl/memory_responder.sv
// Byte-wide synchronous RAM, read-first on collisions, gated by an INIT/RUN sequencer.
// Optional macro CLEAR_ON_RESET_EN: sweep 8'h00 through every address after each reset before going ready.
module memory_responder #(
    parameter int addr_width = 9
) (
    input logic               clk,
    input logic               reset_n,
    memory_responder_if.slave bus
);
    // state | meaning
    // INIT  | after reset; writes ignored, read data forced to zero, optional clear sweep
    // RUN   | normal read/write service until the next reset

    localparam int depth = 1 << addr_width;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [7:0]            mem [depth];
    logic [7:0]            data_out;
    logic                  we;
    logic [addr_width-1:0] wa;
    logic [7:0]            wd;

`ifdef CLEAR_ON_RESET_EN
    logic [addr_width-1:0] init_cnt;
    logic                  sweep_done;

    // sweep_done adds the one extra INIT edge after the last address is cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt   <= '0;
            sweep_done <= 1'b0;
        end else if (state == INIT && !sweep_done) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == {addr_width{1'b1}})
                sweep_done <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= INIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        we         = 1'b0;
        wa         = bus.mem_waddr;
        wd         = bus.mem_data_in;
        case (state)
            INIT: begin
`ifdef CLEAR_ON_RESET_EN
                if (sweep_done) begin
                    state_next = RUN;
                end else begin
                    we = 1'b1;
                    wa = init_cnt;
                    wd = 8'h00;
                end
`else
                state_next = RUN;
`endif
            end
            RUN:     we = bus.mem_write;
            default: state_next = INIT;
        endcase
    end

    // array has no reset so contents survive reset_n
    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            data_out <= 8'h00;
        else if (state == INIT)
            data_out <= 8'h00;
        else
            data_out <= mem[bus.mem_raddr];
    end

    assign bus.mem_data_out = data_out;
    assign bus.mem_ready    = (state == RUN);
endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: random and directed traffic against an array model.
module tb_memory_responder;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;
`ifdef CLEAR_ON_RESET_EN
    localparam int LAT = DEPTH + 1;
`else
    localparam int LAT = 1;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    memory_responder_if #(.addr_width(AW)) bus ();

    memory_responder #(.addr_width(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         data_known;
        bit         ready;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_mem   [DEPTH];
    bit         model_known [DEPTH];
    int         edges_since_release = 0;
    bit         chk_valid = 1'b0;
    int         checks = 0;
    int         passes = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act === req)
            passes++;
        else
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // monitor: one expected entry per driven edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (chk_valid) begin
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL scoreboard_underflow: got empty queue, expected an entry (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_ready", {7'd0, bus.mem_ready}, {7'd0, e.ready});
                    if (e.data_known)
                        check("mem_data_out", bus.mem_data_out, e.data);
                end
            end
        end
    end

    // Called at a negedge: drives one edge's worth of inputs, predicts the result, returns at the next negedge.
    task automatic cycle(input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                         input logic [7:0] wd, input logic wr);
        exp_t e;
        bus.mem_raddr   = ra;
        bus.mem_waddr   = wa;
        bus.mem_data_in = wd;
        bus.mem_write   = wr;
        chk_valid       = 1'b1;
        edges_since_release++;
        if (edges_since_release <= LAT) begin
            e.data       = 8'h00;
            e.data_known = 1'b1;
        end else begin
            e.data       = model_mem[ra];
            e.data_known = model_known[ra];
            if (wr) begin
                model_mem[wa]   = wd;
                model_known[wa] = 1'b1;
            end
        end
        e.ready = (edges_since_release >= LAT);
        exp_q.push_back(e);
        @(negedge clk);
        chk_valid     = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic release_reset();
        reset_n             = 1'b1;
        edges_since_release = 0;
`ifdef CLEAR_ON_RESET_EN
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = 8'h00;
            model_known[i] = 1'b1;
        end
`endif
    endtask

    // Reset lands mid-cycle, so outputs must fall without a clock edge.
    task automatic pulse_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_ready", {7'd0, bus.mem_ready}, 8'h00);
        check("async_data_out", bus.mem_data_out, 8'h00);
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH + LAT + 4; i++)
            cycle(AW'(i % DEPTH), '0, 8'h00, 1'b0);
    endtask

    initial begin
        bus.mem_raddr   = '0;
        bus.mem_waddr   = '0;
        bus.mem_data_in = 8'h00;
        bus.mem_write   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = 8'h00;
            model_known[i] = 1'b0;
        end

        repeat (2) @(negedge clk);
        check("reset_ready", {7'd0, bus.mem_ready}, 8'h00);
        check("reset_data_out", bus.mem_data_out, 8'h00);
        release_reset();

        // first edge after release is INIT: this write must be dropped
        cycle(AW'(16), AW'(16), 8'h77, 1'b1);

        for (int i = 0; i < DEPTH; i++)
            cycle(AW'($urandom), AW'(i), 8'($urandom), 1'b1);

        cycle('0, AW'(16), 8'hA5, 1'b1);
        cycle(AW'(16), '0, 8'h00, 1'b0);

        cycle('0, AW'(9'h100), 8'h11, 1'b1);
        cycle('0, AW'(9'h101), 8'h22, 1'b1);
        cycle('0, AW'(9'h102), 8'h33, 1'b1);
        cycle('0, AW'(9'h103), 8'h44, 1'b1);
        for (int i = 0; i < 4; i++)
            cycle(AW'(9'h100 + i), '0, 8'h00, 1'b0);

        cycle('0, AW'(9'h020), 8'h5A, 1'b1);
        cycle(AW'(9'h020), AW'(9'h020), 8'hC3, 1'b1);
        cycle(AW'(9'h020), '0, 8'h00, 1'b0);

        cycle(AW'(9'h1FF), '0, 8'h00, 1'b0);
        cycle(AW'(9'h000), '0, 8'h00, 1'b0);
        cycle(AW'(9'h1FF), '0, 8'h00, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0)
                cycle(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                      8'($urandom), 1'($urandom));
            else
                cycle(AW'($urandom), AW'($urandom), 8'($urandom), 1'($urandom));
        end

        cycle('0, AW'(9'h033), 8'hA5, 1'b1);
        cycle(AW'(9'h033), '0, 8'h00, 1'b0);
        pulse_reset();
        read_all();

`ifdef CLEAR_ON_RESET_EN
        for (int i = 0; i < DEPTH; i++)
            cycle('0, AW'(i), 8'hFF, 1'b1);
        cycle(AW'(9'h001), '0, 8'h00, 1'b0);
        pulse_reset();
        for (int i = 0; i < 200; i++)
            cycle(AW'(1), AW'(1), 8'h77, 1'b1);
        pulse_reset();
        read_all();
`endif

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() == 0)
            passes++;
        else
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter: addr_width, default 9, address bits; depth = 2^addr_width bytes.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 mem_raddr  input  addr_width  read byte address from CPU.
REQ-005 mem_waddr  input  addr_width  write byte address from CPU.
REQ-006 mem_data_in  input  8  write data from CPU.
REQ-007 mem_write  input  1  write strobe, one byte per asserted cycle.
REQ-008 mem_data_out  output  8  registered read data to CPU.
REQ-009 mem_ready  output  1  high = array usable; low = initialisation in progress.

Function
REQ-010 Storage SHALL be a byte array of 2^addr_width entries; the array SHALL NOT be reset by reset_n.
REQ-011 Read SHALL be synchronous, one cycle: at each edge, mem_data_out <= array[mem_raddr]; a new address every cycle yields one byte per cycle (fully pipelined).
REQ-012 Write SHALL occur at an edge where mem_write=1 and mem_ready=1: array[mem_waddr] <= mem_data_in; no acknowledge.
REQ-013 Read and write at the same edge to the same address SHALL be read-first: mem_data_out gets the old byte; the new byte is visible from the next read.
REQ-014 Read and write at the same edge to different addresses SHALL both complete independently.
REQ-015 Addresses SHALL wrap modulo 2^addr_width; there are no out-of-range errors.
REQ-016 State machine SHALL have states INIT and RUN; INIT -> RUN per REQ-022/REQ-023; RUN is held until reset.
REQ-017 In INIT, mem_write SHALL be ignored, and mem_data_out SHALL be driven 8'h00 on every edge.
REQ-018 mem_ready SHALL be registered and high exactly when state is RUN.

Reset
REQ-019 On reset_n low, asynchronously: state=INIT, mem_ready=0, mem_data_out=8'h00, init counter=0.
REQ-020 Reset asserted mid-initialisation SHALL abort the sweep; after release, initialisation restarts from address 0.
REQ-021 Reset asserted in RUN SHALL leave array contents untouched when CLEAR_ON_RESET_EN is undefined.

Configuration
REQ-022 With CLEAR_ON_RESET_EN defined, INIT SHALL write 8'h00 to addresses 0..2^addr_width-1 in ascending order, one per cycle, using an addr_width-bit counter. After the final address is written, state goes to RUN on the next edge. mem_ready therefore rises 2^addr_width+1 edges after reset_n release (513 for addr_width=9).
REQ-023 With CLEAR_ON_RESET_EN undefined, no sweep SHALL occur: INIT -> RUN on the first edge after reset_n release, mem_ready rises 1 edge after release, and the counter SHALL be omitted.

Verification
REQ-024 Macro undefined, addr_width=9: release reset, write 8'hA5 to 0x010 -> mem_ready=1 at edge 1; mem_data_out=8'hA5 one edge after mem_raddr=0x010.
REQ-025 Pipelined read: preload 0x100..0x103 = 11,22,33,44; present addresses 0x100..0x103 on consecutive cycles -> mem_data_out = 11,22,33,44 on consecutive edges, one cycle after each address.
REQ-026 Collision: array[0x020]=8'h5A; same edge mem_raddr=mem_waddr=0x020, mem_data_in=8'hC3, mem_write=1 -> mem_data_out=8'h5A; next read of 0x020 -> 8'hC3.
REQ-027 Macro defined: fill array with 8'hFF, pulse reset, write 8'h77 to 0x001 during INIT -> mem_ready low for 513 edges; write ignored; every address then reads 8'h00.
REQ-028 Macro defined: assert reset_n low at sweep address 0x0C8 for 2 cycles, then release -> mem_ready and mem_data_out drop to 0 without waiting for clk; sweep restarts at 0x000; mem_ready rises 513 edges after release.
REQ-029 Wrap: mem_raddr=0x1FF then 0x000 -> consecutive bytes returned, no stall, mem_ready stays 1.
